alu_iterative: RTL and testbench

// - Execution unit that consumes the ALU_ctl code emitted by alu_control and returns a result with a valid/ready handshake.
// - Add, subtract, logic and set-less-than complete in one cycle. SLL/SRL iterate SHIFT_STEP bits per cycle, which removes the barrel shifter.
// - Sits between ID (operands + ALU_ctl) and EX/branch logic. zero/result feed beq/blt resolution and writeback.

---
 rtl/alu_iterative_pkg.sv | 35 +++
 rtl/alu_iterative_if.sv | 30 +++
 rtl/alu_shift_step.sv | 37 +++
 rtl/alu_iterative.sv | 157 +++++++++++++++
 tb/tb_alu_iterative.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_iterative_pkg.sv
// Shared definitions for the iterative ALU: operation codes, FSM state
// encoding and small decode helpers used by the unit and its interface.
package alu_iterative_pkg;

    // Operation code width and encodings produced by alu_control.
    localparam int ALU_CONTROL_WIDTH = 4;

    typedef logic [ALU_CONTROL_WIDTH-1:0] alu_ctl_t;

    localparam alu_ctl_t ALU_ADD  = 4'd0;
    localparam alu_ctl_t ALU_SUB  = 4'd1;
    localparam alu_ctl_t ALU_XOR  = 4'd2;
    localparam alu_ctl_t ALU_OR   = 4'd3;
    localparam alu_ctl_t ALU_AND  = 4'd4;
    localparam alu_ctl_t ALU_LT   = 4'd5;
    localparam alu_ctl_t ALU_SLL  = 4'd6;
    localparam alu_ctl_t ALU_SRL  = 4'd7;
    localparam alu_ctl_t ALU_NULL = 4'd8;   // jal: no computation, result 0
    // Codes 9..15 are undefined and flagged as illegal.

    // FSM state encoding.
    localparam int ALU_ST_WIDTH = 2;

    typedef enum logic [ALU_ST_WIDTH-1:0] {
        ALU_ST_IDLE  = 2'd0,
        ALU_ST_SHIFT = 2'd1,
        ALU_ST_DONE  = 2'd2
    } alu_state_t;

    // True for the two operations that iterate in the SHIFT state.
    function automatic logic is_shift_op(input alu_ctl_t ctl);
        return (ctl == ALU_SLL) || (ctl == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// Operand/result bus of the iterative ALU: one valid/ready channel for the
// request (operands + op code) and one for the response (result + flags).
interface alu_iterative_if
    import alu_iterative_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    alu_ctl_t        alu_ctl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    // Producer of operations and consumer of results (ID/EX side).
    modport master (
        output in_valid, alu_ctl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    // The execution unit itself.
    modport slave (
        input  in_valid, alu_ctl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_shift_step.sv
// Combinational step shifter: shifts data left or right (zero fill) by an
// amount no larger than SHIFT_STEP. Only log2(SHIFT_STEP)+1 mux stages are
// built, so with small steps this stays far cheaper than a barrel shifter.
module alu_shift_step #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int AW         = $clog2(SHIFT_STEP) + 1
) (
    input  logic [XLEN-1:0] data_in,
    input  logic            shift_left,
    input  logic [AW-1:0]   amount,
    output logic [XLEN-1:0] data_out
);

    // stage[gi] is the data after the first gi amount bits were applied.
    logic [AW:0][XLEN-1:0] stage;

    assign stage[0] = data_in;

    genvar gi;
    generate
        for (gi = 0; gi < AW; gi++) begin : g_stage
            localparam int DIST = 1 << gi;
            if (DIST >= XLEN) begin : g_flush
                // A full-width shift clears everything in either direction.
                assign stage[gi+1] = amount[gi] ? '0 : stage[gi];
            end else begin : g_shift
                assign stage[gi+1] = amount[gi]
                                   ? (shift_left ? (stage[gi] << DIST) : (stage[gi] >> DIST))
                                   : stage[gi];
            end
        end
    endgenerate

    assign data_out = stage[AW];

endmodule

// File: rtl/alu_iterative.sv
// Iterative ALU: single-cycle add/sub/logic/compare, multi-cycle SLL/SRL
// that advance SHIFT_STEP bits per cycle. Valid/ready on both sides; the
// result registers hold steady while the consumer stalls.
module alu_iterative
    import alu_iterative_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_iterative_if.slave bus
);

    // Remaining-count width covers shamt (5 bits) and SHIFT_STEP itself.
    localparam int RW = $clog2(XLEN) + 1;
    // Step amount width fed to the step shifter (0..SHIFT_STEP).
    localparam int AW = $clog2(SHIFT_STEP) + 1;

    alu_state_t      state_reg, state_next;
    logic [XLEN-1:0] shift_data_reg, shift_data_next;
    logic [RW-1:0]   remaining_reg, remaining_next;
    logic            shift_left_reg, shift_left_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            zero_reg, zero_next;
    logic            illegal_reg, illegal_next;

    logic            in_ready;
    logic            accept;
    logic [RW-1:0]   shamt_in;
    logic [AW-1:0]   step_amt;
    logic [XLEN-1:0] stepped_data;
    logic [XLEN-1:0] single_result;
    logic            single_illegal;

    // A new op can enter when idle, or when the held result leaves this cycle.
    assign in_ready = (state_reg == ALU_ST_IDLE) ||
                      ((state_reg == ALU_ST_DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign shamt_in = RW'(bus.op_b[4:0]);

    // Per-cycle shift distance: a full step, or whatever is left if smaller.
    always_comb begin
        step_amt = '0;
        if (remaining_reg >= RW'(SHIFT_STEP)) begin
            step_amt = AW'(SHIFT_STEP);
        end else begin
            step_amt = remaining_reg[AW-1:0];
        end
    end

    alu_shift_step #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP),
        .AW         (AW)
    ) u_shift_step (
        .data_in    (shift_data_reg),
        .shift_left (shift_left_reg),
        .amount     (step_amt),
        .data_out   (stepped_data)
    );

    // Result of every op that finishes at the accept edge.
    always_comb begin
        single_result  = '0;
        single_illegal = 1'b0;
        case (bus.alu_ctl)
            ALU_ADD:  single_result = bus.op_a + bus.op_b;
            ALU_SUB:  single_result = bus.op_a - bus.op_b;
            ALU_XOR:  single_result = bus.op_a ^ bus.op_b;
            ALU_OR:   single_result = bus.op_a | bus.op_b;
            ALU_AND:  single_result = bus.op_a & bus.op_b;
            ALU_LT:   single_result = {{(XLEN-1){1'b0}},
                                       ($signed(bus.op_a) < $signed(bus.op_b))};
            // Only reached with shamt == 0: the operand passes through.
            ALU_SLL,
            ALU_SRL:  single_result = bus.op_a;
            ALU_NULL: single_result = '0;
            default:  single_illegal = 1'b1;
        endcase
    end

    // Next-state, shift datapath and output register updates.
    always_comb begin
        state_next      = state_reg;
        shift_data_next = shift_data_reg;
        remaining_next  = remaining_reg;
        shift_left_next = shift_left_reg;
        result_next     = result_reg;
        zero_next       = zero_reg;
        illegal_next    = illegal_reg;

        case (state_reg)
            ALU_ST_IDLE,
            ALU_ST_DONE: begin
                if (accept) begin
                    if (is_shift_op(bus.alu_ctl) && (shamt_in != '0)) begin
                        state_next      = ALU_ST_SHIFT;
                        shift_data_next = bus.op_a;
                        remaining_next  = shamt_in;
                        shift_left_next = (bus.alu_ctl == ALU_SLL);
                    end else begin
                        state_next   = ALU_ST_DONE;
                        result_next  = single_result;
                        zero_next    = (single_result == '0);
                        illegal_next = single_illegal;
                    end
                end else if ((state_reg == ALU_ST_DONE) && bus.out_ready) begin
                    state_next = ALU_ST_IDLE;
                end
            end

            ALU_ST_SHIFT: begin
                shift_data_next = stepped_data;
                remaining_next  = remaining_reg - RW'(step_amt);
                if (remaining_next == '0) begin
                    state_next   = ALU_ST_DONE;
                    result_next  = stepped_data;
                    zero_next    = (stepped_data == '0);
                    illegal_next = 1'b0;
                end
            end

            default: begin
                state_next = ALU_ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any op in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ALU_ST_IDLE;
            shift_data_reg <= '0;
            remaining_reg  <= '0;
            shift_left_reg <= 1'b0;
            result_reg     <= '0;
            zero_reg       <= 1'b0;
            illegal_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_data_reg <= shift_data_next;
            remaining_reg  <= remaining_next;
            shift_left_reg <= shift_left_next;
            result_reg     <= result_next;
            zero_reg       <= zero_next;
            illegal_reg    <= illegal_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_reg == ALU_ST_DONE);
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: three instances (SHIFT_STEP 1, 4, 32) share the
// same stimulus. Directed vector table, hand-written multi-cycle sequences
// (reset mid-shift, backpressure, input changes during SHIFT) and random ops
// checked against a behavioural reference.
module tb_alu_iterative;
    import alu_iterative_pkg::*;

    localparam int XLEN = 32;
    localparam int NDUT = 3;
    localparam int NVEC = 18;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    alu_ctl_t        alu_ctl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_iterative_if #(.XLEN(XLEN)) bus1 ();
    alu_iterative_if #(.XLEN(XLEN)) bus4 ();
    alu_iterative_if #(.XLEN(XLEN)) bus32 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.alu_ctl   = alu_ctl;
    assign bus1.op_a      = op_a;
    assign bus1.op_b      = op_b;
    assign bus1.out_ready = out_ready;
    assign bus4.in_valid  = in_valid;
    assign bus4.alu_ctl   = alu_ctl;
    assign bus4.op_a      = op_a;
    assign bus4.op_b      = op_b;
    assign bus4.out_ready = out_ready;
    assign bus32.in_valid  = in_valid;
    assign bus32.alu_ctl   = alu_ctl;
    assign bus32.op_a      = op_a;
    assign bus32.op_b      = op_b;
    assign bus32.out_ready = out_ready;

    alu_iterative #(.XLEN(XLEN), .SHIFT_STEP(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_iterative #(.XLEN(XLEN), .SHIFT_STEP(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    alu_iterative #(.XLEN(XLEN), .SHIFT_STEP(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    logic            ov  [NDUT];
    logic            rdy [NDUT];
    logic [XLEN-1:0] res [NDUT];
    logic            zr  [NDUT];
    logic            il  [NDUT];

    assign ov[0]  = bus1.out_valid;
    assign ov[1]  = bus4.out_valid;
    assign ov[2]  = bus32.out_valid;
    assign rdy[0] = bus1.in_ready;
    assign rdy[1] = bus4.in_ready;
    assign rdy[2] = bus32.in_ready;
    assign res[0] = bus1.result;
    assign res[1] = bus4.result;
    assign res[2] = bus32.result;
    assign zr[0]  = bus1.zero;
    assign zr[1]  = bus4.zero;
    assign zr[2]  = bus32.zero;
    assign il[0]  = bus1.illegal;
    assign il[1]  = bus4.illegal;
    assign il[2]  = bus32.illegal;

    typedef struct {
        alu_ctl_t        ctl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp_res;
        logic            exp_zero;
        logic            exp_ill;
        int              exp_lat1;   // latency with SHIFT_STEP = 1
    } vec_t;

    vec_t vecs [NVEC];

    // Captured response of each instance for the last run_op.
    logic [XLEN-1:0] got_res  [NDUT];
    logic            got_zero [NDUT];
    logic            got_ill  [NDUT];
    int              got_lat  [NDUT];

    function automatic int step_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 32;
        endcase
    endfunction

    // Accept-to-out_valid latency in cycles.
    function automatic int lat_model(input alu_ctl_t c, input logic [XLEN-1:0] b, input int step);
        int sh;
        sh = int'(b[4:0]);
        if (((c == ALU_SLL) || (c == ALU_SRL)) && (sh != 0))
            return (sh + step - 1) / step + 1;
        return 1;
    endfunction

    // Behavioural reference; {illegal, result}.
    function automatic logic [XLEN:0] ref_alu(input alu_ctl_t c, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        logic            ill;
        r   = '0;
        ill = 1'b0;
        case (c)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_LT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_NULL: r = '0;
            default:  ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op to all instances, then wait for each response with
    // out_ready held high. Operands are scrambled right after the accept.
    task automatic run_op(input alu_ctl_t c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bit seen [NDUT];
        int k;
        for (int i = 0; i < NDUT; i++) seen[i] = 1'b0;
        @(negedge clk);
        alu_ctl  = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < NDUT; i++)
            check($sformatf("in_ready_before_op_s%0d", step_of(i)), 32'(rdy[i]), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        k = 0;
        while (k < 64 && !(seen[0] && seen[1] && seen[2])) begin
            @(negedge clk);
            k++;
            for (int i = 0; i < NDUT; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i]     = 1'b1;
                    got_res[i]  = res[i];
                    got_zero[i] = zr[i];
                    got_ill[i]  = il[i];
                    got_lat[i]  = k;
                end
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            if (!seen[i]) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout_s%0d: out_valid never rose in 64 cycles, expected within %0d",
                         step_of(i), lat_model(c, b, step_of(i)));
                got_lat[i] = -1;
            end
        end
        $display("op ctl=%0d a=%08h b=%08h -> res %08h/%08h/%08h lat %0d/%0d/%0d",
                 c, a, b, got_res[0], got_res[1], got_res[2], got_lat[0], got_lat[1], got_lat[2]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int stale;
        logic [XLEN:0] rm;
        alu_ctl_t rc;
        logic [XLEN-1:0] ra, rb;

        vecs[0]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[1]  = '{ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
        vecs[2]  = '{ALU_SUB,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[3]  = '{ALU_LT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1};
        vecs[4]  = '{ALU_LT,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[5]  = '{ALU_LT,   32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1};
        vecs[6]  = '{ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 32};
        vecs[7]  = '{ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 5};
        vecs[8]  = '{ALU_SLL,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b0, 1'b0, 1};
        vecs[9]  = '{ALU_SRL,  32'hF000_0000, 32'hFFFF_FFE3, 32'h1E00_0000, 1'b0, 1'b0, 4};
        vecs[10] = '{ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1};
        vecs[11] = '{ALU_OR,   32'h0000_FFFF, 32'h1234_0000, 32'h1234_FFFF, 1'b0, 1'b0, 1};
        vecs[12] = '{ALU_AND,  32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 1'b0, 1'b0, 1};
        vecs[13] = '{ALU_NULL, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[14] = '{4'hF,     32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1'b1, 1};
        vecs[15] = '{ALU_ADD,  32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1};
        vecs[16] = '{ALU_SLL,  32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 2};
        vecs[17] = '{ALU_SRL,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_ctl   = ALU_ADD;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_out_valid_s%0d", step_of(i)), 32'(ov[i]), 32'd0);
            check($sformatf("rst_result_s%0d", step_of(i)), res[i], 32'd0);
            check($sformatf("rst_zero_s%0d", step_of(i)), 32'(zr[i]), 32'd0);
            check($sformatf("rst_illegal_s%0d", step_of(i)), 32'(il[i]), 32'd0);
        end
        rst_n = 1'b1;

        // Reset in the middle of SLL by 20 on the single-step unit.
        @(negedge clk);
        alu_ctl  = ALU_SLL;
        op_a     = 32'h0000_0001;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midshift_out_valid", 32'(ov[0]), 32'd0);
        check("midshift_in_ready", 32'(rdy[0]), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_midshift_out_valid", 32'(ov[0]), 32'd0);
        check("rst_midshift_result", res[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", 32'(rdy[0]), 32'd1);
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (ov[0] !== 1'b0) stale++;
        end
        check("rst_no_stale_output", 32'(stale), 32'd0);

        // Directed vector table on all three step sizes.
        for (int v = 0; v < NVEC; v++) begin
            run_op(vecs[v].ctl, vecs[v].a, vecs[v].b);
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("vec%0d_result_s%0d", v, step_of(i)), got_res[i], vecs[v].exp_res);
                check($sformatf("vec%0d_zero_s%0d", v, step_of(i)), 32'(got_zero[i]), 32'(vecs[v].exp_zero));
                check($sformatf("vec%0d_illegal_s%0d", v, step_of(i)), 32'(got_ill[i]), 32'(vecs[v].exp_ill));
                if (i == 0)
                    check($sformatf("vec%0d_latency_s1", v), 32'(got_lat[i]), 32'(vecs[v].exp_lat1));
                else
                    check($sformatf("vec%0d_latency_s%0d", v, step_of(i)), 32'(got_lat[i]),
                          32'(lat_model(vecs[v].ctl, vecs[v].b, step_of(i))));
            end
        end

        // Backpressure: hold ADD result for 10 cycles, then back-to-back AND.
        @(negedge clk);
        out_ready = 1'b0;
        alu_ctl   = ALU_ADD;
        op_a      = 32'd10;
        op_b      = 32'd20;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp_out_valid_c%0d", c), 32'(ov[0]), 32'd1);
            check($sformatf("bp_result_c%0d", c), res[0], 32'd30);
            check($sformatf("bp_in_ready_c%0d", c), 32'(rdy[0]), 32'd0);
            op_a = $urandom;
            op_b = $urandom;
        end
        @(negedge clk);
        alu_ctl   = ALU_AND;
        op_a      = 32'hFF00_FF00;
        op_b      = 32'h0FF0_0FF0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(rdy[0]), 32'd1);
        check("bp_release_result", res[0], 32'd30);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_out_valid", 32'(ov[0]), 32'd1);
        check("b2b_result", res[0], 32'h0F00_0F00);
        check("b2b_illegal", 32'(il[0]), 32'd0);

        // SLL 3 by 8: inputs change and in_valid is raised during SHIFT.
        @(negedge clk);
        alu_ctl  = ALU_SLL;
        op_a     = 32'd3;
        op_b     = 32'd8;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctl  = ALU_ADD;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'd0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (k == 2) begin
                check("shift_in_ready", 32'(rdy[0]), 32'd0);
                in_valid = 1'b1;
            end
            if (ov[0]) break;
        end
        check("shift_hold_latency", 32'(k), 32'd9);
        check("shift_hold_result", res[0], 32'h0000_0300);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("held_valid_out_valid", 32'(ov[0]), 32'd1);
        check("held_valid_result", res[0], 32'hDEAD_BEEF);
        $display("shift-then-held-op done: result %08h", res[0]);

        // Random ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            rc = alu_ctl_t'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            rm = ref_alu(rc, ra, rb);
            run_op(rc, ra, rb);
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("rnd%0d_result_s%0d", n, step_of(i)), got_res[i], rm[XLEN-1:0]);
                check($sformatf("rnd%0d_zero_s%0d", n, step_of(i)), 32'(got_zero[i]),
                      32'(rm[XLEN-1:0] == '0));
                check($sformatf("rnd%0d_illegal_s%0d", n, step_of(i)), 32'(got_ill[i]), 32'(rm[XLEN]));
                check($sformatf("rnd%0d_latency_s%0d", n, step_of(i)), 32'(got_lat[i]),
                      32'(lat_model(rc, rb, step_of(i))));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
